// File: rtl/reg_bank_sv.sv
// Peripheral register bank responder: REQ/ACK bus, R/W control registers,
// W1C sticky status and a saturating clear-on-read event counter.
module reg_bank_sv #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_CTRL = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       REQ,
  input  logic                       WE,
  input  logic [ADDR_W-1:0]          ADDR,
  input  logic [DATA_W-1:0]          WD,
  output logic                       ACK,
  output logic [DATA_W-1:0]          RD,
  output logic                       ERR,
  output logic [NUM_CTRL*DATA_W-1:0] CTRL,
  input  logic [DATA_W-1:0]          EV_SET,
  input  logic                       EV_INC,
  output logic                       IRQ
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(NUM_CTRL);
  localparam logic [ADDR_W-1:0] EVC_A  = ADDR_W'(NUM_CTRL + 1);
  localparam logic [DATA_W-1:0] SAT    = '1;

  state_t            state_q;
  logic [DATA_W-1:0] ctrl_q [NUM_CTRL];
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] evcnt_q;

  logic              accept;
  logic              hit_ctrl;
  logic              hit_stat;
  logic              hit_evc;
  logic              mapped;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] w1c;
  logic              evc_clr;

  assign accept = (state_q == IDLE) && REQ;

  always_comb begin
    hit_ctrl = 1'b0;
    rd_mux   = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (ADDR == ADDR_W'(i)) begin
        hit_ctrl = 1'b1;
        rd_mux   = ctrl_q[i];
      end
    end
    hit_stat = (ADDR == STAT_A);
    hit_evc  = (ADDR == EVC_A);
    if (hit_stat) rd_mux = status_q;
    if (hit_evc)  rd_mux = evcnt_q;
    mapped = hit_ctrl | hit_stat | hit_evc;
  end

  // side effects are gated by accept so idle-bus X cannot leak into state
  assign w1c     = (accept && WE && hit_stat) ? WD : '0;
  assign evc_clr = accept && !WE && hit_evc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      ACK      <= 1'b0;
      RD       <= '0;
      ERR      <= 1'b0;
      status_q <= '0;
      evcnt_q  <= '0;
      for (int i = 0; i < NUM_CTRL; i++)
        ctrl_q[i] <= '0;
    end else begin
      status_q <= (status_q & ~w1c) | EV_SET;

      if (evc_clr)
        evcnt_q <= EV_INC ? DATA_W'(1) : '0;
      else if (EV_INC && evcnt_q != SAT)
        evcnt_q <= evcnt_q + DATA_W'(1);

      case (state_q)
        IDLE: begin
          if (REQ) begin
            state_q <= RESP;
            ACK     <= 1'b1;
            ERR     <= !mapped;
            RD      <= (!WE && mapped) ? rd_mux : '0;
            if (WE) begin
              for (int i = 0; i < NUM_CTRL; i++)
                if (ADDR == ADDR_W'(i)) ctrl_q[i] <= WD;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          ACK     <= 1'b0;
          RD      <= '0;
          ERR     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign CTRL[g*DATA_W +: DATA_W] = ctrl_q[g];
  end

  assign IRQ = |status_q;

endmodule

// File: tb/tb_reg_bank_sv.sv
// Directed bench for reg_bank_sv: vector table of bus transactions plus
// hand-written counter, handshake and reset sequences.
module tb_reg_bank_sv;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        WE = 1'b0;
  logic [3:0]  ADDR = '0;
  logic [7:0]  WD = '0;
  logic        ACK;
  logic [7:0]  RD;
  logic        ERR;
  logic [31:0] CTRL;
  logic [7:0]  EV_SET = '0;
  logic        EV_INC = 1'b0;
  logic        IRQ;

  int tests = 0;
  int fails = 0;

  reg_bank_sv #(.DATA_W(8), .ADDR_W(4), .NUM_CTRL(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WD(WD),
    .ACK(ACK), .RD(RD), .ERR(ERR), .CTRL(CTRL),
    .EV_SET(EV_SET), .EV_INC(EV_INC), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  ev_set;
    logic        ev_inc;
    logic [7:0]  rd;
    logic        err;
    logic [31:0] ctrl;
    logic        irq;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one request: accepted at the next edge, ACK sampled 1ns later
  task automatic xact(input logic we, input logic [3:0] addr,
                      input logic [7:0] wd, input logic [7:0] evs,
                      input logic evi, output logic ack,
                      output logic [7:0] rd, output logic err);
    @(negedge CLK);
    REQ = 1'b1; WE = we; ADDR = addr; WD = wd;
    EV_SET = evs; EV_INC = evi;
    @(posedge CLK); #1;
    ack = ACK; rd = RD; err = ERR;
    REQ = 1'b0; WE = 1'bx; ADDR = 'x; WD = 'x;
    EV_SET = '0; EV_INC = 1'b0;
    @(posedge CLK); #1;
    chk("ack_drop", {31'd0, ACK}, 32'd0);
    chk("rd_idle", {24'd0, RD}, 32'd0);
    chk("err_idle", {31'd0, ERR}, 32'd0);
  endtask

  task automatic pulse(input logic [7:0] evs, input logic evi);
    @(negedge CLK);
    EV_SET = evs; EV_INC = evi;
    @(posedge CLK); #1;
    EV_SET = '0; EV_INC = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr,
                        input logic evi, input logic [7:0] exp);
    logic a, e;
    logic [7:0] r;
    xact(1'b0, addr, 8'h00, 8'h00, evi, a, r, e);
    chk({name, "_ack"}, {31'd0, a}, 32'd1);
    chk({name, "_rd"}, {24'd0, r}, {24'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic a, e;
    logic [7:0] r;
    //        we    addr   wd     evset  inc   rd     err   ctrl          irq
    vecs[0]  = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 4'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 4'd2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, 4'd4, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[5]  = '{1'b0, 4'd5, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 4'd2, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00A50000, 1'b0};
    vecs[7]  = '{1'b0, 4'd2, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 32'h00A50000, 1'b0};
    vecs[8]  = '{1'b1, 4'd0, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0, 32'h00A5003C, 1'b0};
    vecs[9]  = '{1'b1, 4'd3, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 32'hFFA5003C, 1'b0};
    vecs[10] = '{1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 32'hFFA5003C, 1'b0};
    vecs[11] = '{1'b0, 4'd4, 8'h00, 8'h81, 1'b0, 8'h00, 1'b0, 32'hFFA5003C, 1'b1};
    vecs[12] = '{1'b1, 4'd4, 8'h81, 8'h01, 1'b0, 8'h00, 1'b0, 32'hFFA5003C, 1'b1};
    vecs[13] = '{1'b0, 4'd4, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 32'hFFA5003C, 1'b1};
    vecs[14] = '{1'b1, 4'd4, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 32'hFFA5003C, 1'b0};
    vecs[15] = '{1'b0, 4'd4, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'hFFA5003C, 1'b0};
    vecs[16] = '{1'b1, 4'd9, 8'h55, 8'h00, 1'b0, 8'h00, 1'b1, 32'hFFA5003C, 1'b0};
    vecs[17] = '{1'b0, 4'd9, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 32'hFFA5003C, 1'b0};
    vecs[18] = '{1'b1, 4'd5, 8'h77, 8'h00, 1'b0, 8'h00, 1'b0, 32'hFFA5003C, 1'b0};
    vecs[19] = '{1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h3C, 1'b0, 32'hFFA5003C, 1'b0};
    vecs[20] = '{1'b0, 4'd15, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 32'hFFA5003C, 1'b0};

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_ack", {31'd0, ACK}, 32'd0);
    chk("rst_rd", {24'd0, RD}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_ctrl", CTRL, 32'd0);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);

    for (int i = 0; i < 21; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].ev_set,
           vecs[i].ev_inc, a, r, e);
      chk($sformatf("v%0d_ack", i), {31'd0, a}, 32'd1);
      chk($sformatf("v%0d_rd", i), {24'd0, r}, {24'd0, vecs[i].rd});
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_ctrl", i), CTRL, vecs[i].ctrl);
      chk($sformatf("v%0d_irq", i), {31'd0, IRQ}, {31'd0, vecs[i].irq});
    end

    // event counter: read-clear racing an increment, then saturation
    repeat (3) pulse(8'h00, 1'b1);
    rd_chk("evc_race", 4'd5, 1'b1, 8'h03);
    rd_chk("evc_one", 4'd5, 1'b0, 8'h01);
    repeat (300) pulse(8'h00, 1'b1);
    rd_chk("evc_sat", 4'd5, 1'b0, 8'hFF);
    rd_chk("evc_clr", 4'd5, 1'b0, 8'h00);

    // REQ held high: one ACK every two cycles, then reset in RESP
    pulse(8'h10, 1'b0);
    chk("irq_set", {31'd0, IRQ}, 32'd1);
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b0; ADDR = 4'd0;
    chk("hs_ack0", {31'd0, ACK}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("hs_ack%0d", k + 1), {31'd0, ACK}, {31'd0, ~k[0]});
      if (ACK) chk($sformatf("hs_rd%0d", k + 1), {24'd0, RD}, 32'h3C);
    end
    @(posedge CLK); #1;
    chk("hs_resp", {31'd0, ACK}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; REQ = 1'b0;
    chk("mid_rst_ack", {31'd0, ACK}, 32'd0);
    chk("mid_rst_rd", {24'd0, RD}, 32'd0);
    chk("mid_rst_ctrl", CTRL, 32'd0);
    chk("mid_rst_irq", {31'd0, IRQ}, 32'd0);
    rd_chk("post_rst", 4'd3, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
